// File: rtl/rrns_enc_scheduler.sv
// Round-robin scheduler sharing one RRNS encoder among NUM_REQ requesters.
// Optional WAIT timeout enabled by defining RRNS_SCHED_TIMEOUT_EN.
module rrns_enc_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   enc_start,
    output logic [15:0]            enc_data,
    input  logic                   enc_done,
    input  logic [60:0]            enc_rem,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [60:0]            out_code,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t state, state_n;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] pick;
    logic [ID_W:0]   sum;
    logic [15:0]     pick_data;
    logic            found;
    logic            accept;
    logic            done_q;
    logic            done_rise;
    logic            tmo;
    logic            finish;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first valid wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == ID_W'(i))
                pick_data = req_data[16*i +: 16];
        end
    end

    assign accept    = (state == IDLE) && found && !rst;
    assign req_ready = accept ? (NUM_REQ'(1) << pick) : '0;
    assign enc_start = (state == ISSUE);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign finish    = (state == HOLD) && out_ready;

    // Edge detect so a done level left over from the last op is not reused.
    assign done_rise = enc_done & ~done_q;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (found) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (done_rise || tmo) state_n = HOLD;
            HOLD:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant    <= '0;
            enc_data <= '0;
            done_q   <= 1'b0;
            out_code <= '0;
            out_id   <= '0;
        end else begin
            done_q <= enc_done;
            if (accept) begin
                enc_data <= pick_data;
                grant    <= pick;
            end
            if ((state == WAIT) && (done_rise || tmo)) begin
                out_code <= done_rise ? enc_rem : '0;
                out_id   <= grant;
            end
            if (finish) begin
                if (grant == ID_W'(NUM_REQ-1)) rr_ptr <= '0;
                else                           rr_ptr <= grant + 1'b1;
            end
        end
    end

`ifdef RRNS_SCHED_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    // tmo_cnt counts completed WAIT cycles; limit hit in WAIT cycle TIMEOUT_CYC.
    assign tmo     = (state == WAIT) &&
                     (tmo_cnt == 16'(TIMEOUT_CYC - 1));
    assign out_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
            if ((state == WAIT) && (done_rise || tmo))
                err_q <= !done_rise;
        end
    end
`else
    assign tmo     = 1'b0;
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_rrns_enc_scheduler.sv
// Randomized bench for rrns_enc_scheduler with a queue-based round-robin model.
// Timeout cases run only when RRNS_SCHED_TIMEOUT_EN is defined.
module tb_rrns_enc_scheduler;

    localparam int NR = 4;

    typedef struct {
        int          id;
        logic [60:0] code;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [16*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            enc_start;
    logic [15:0]     enc_data;
    logic            enc_done = 1'b0;
    logic [60:0]     enc_rem = '0;
    logic            out_valid;
    logic            out_ready;
    logic [60:0]     out_code;
    logic [1:0]      out_id;
    logic            out_err;
    logic            busy;

    rrns_enc_scheduler #(
        .NUM_REQ(NR),
        .ID_W(2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .enc_start(enc_start),
        .enc_data(enc_data),
        .enc_done(enc_done),
        .enc_rem(enc_rem),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code(out_code),
        .out_id(out_id),
        .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [60:0] pack9(input int a, input int b,
        input int c, input int d, input int e, input int f,
        input int g, input int h, input int i);
        return {6'(a), 6'(b), 7'(c), 7'(d), 7'(e),
                7'(f), 7'(g), 7'(h), 7'(i)};
    endfunction

    function automatic logic [60:0] rns(input logic [15:0] w);
        int v;
        v = int'(w);
        return pack9(v % 64, v % 63, v % 65, v % 67, v % 71,
                     v % 73, v % 79, v % 83, v % 89);
    endfunction

    // Encoder model: done rises enc_lat cycles after start; pulse or level.
    int          enc_lat = 3;
    bit          enc_level = 1'b0;
    int          enc_cnt = 0;
    bit          enc_pend = 1'b0;
    int          enc_pl = 0;
    logic [15:0] enc_word = '0;

    always @(posedge clk) begin
        if (enc_start) begin
            enc_pend <= 1'b1;
            enc_cnt  <= enc_lat;
            enc_word <= enc_data;
            enc_done <= 1'b0;
        end else if (enc_pend) begin
            if (enc_cnt <= 1) begin
                enc_done <= 1'b1;
                enc_rem  <= rns(enc_word);
                enc_pend <= 1'b0;
                enc_pl   <= 1 + int'($urandom_range(2));
            end else begin
                enc_cnt <= enc_cnt - 1;
            end
        end else if (enc_done && !enc_level) begin
            if (enc_pl <= 1) enc_done <= 1'b0;
            else             enc_pl <= enc_pl - 1;
        end
    end

    logic [15:0] req_q[NR][$];
    exp_t        exp_q[$];
    int          m_ptr = 0;
    logic [NR-1:0] hs_snap = '0;
    bit          out_hs = 1'b0;
    bit          inflight = 1'b0;
    bit          prev_ov = 1'b0;
    bit          prev_ordy = 1'b0;
    logic [60:0] prev_code = '0;
    logic [1:0]  prev_id = '0;
    logic [60:0] last_code = '0;
    logic [1:0]  last_id = '0;
    logic [15:0] acc_word = '0;
    int          stall_left = 0;
    int          rdy_pct = 100;
    int          n_start = 0;

    task automatic step();
        exp_t e;
        bit   ok;
        @(negedge clk);
        if (out_hs) inflight = 1'b0;
        out_hs = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (hs_snap[i]) begin
                acc_word = req_q[i].pop_front();
                inflight = 1'b1;
            end
        end
        chk("start", enc_start, hs_snap != '0);
        if (enc_start) begin
            n_start++;
            chk("enc_data", enc_data, acc_word);
        end
        chk("busy", busy, inflight);
        if (prev_ov && !prev_ordy) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_code", out_code, prev_code);
            chk("hold_id", out_id, prev_id);
        end
        if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
        end
        if (out_valid && out_ready) begin
            out_hs = 1'b1;
            last_code = out_code;
            last_id = out_id;
            if (exp_q.size() == 0) begin
                chk("out_unexpected", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_id", out_id, e.id);
                chk("out_code", out_code, e.code);
                chk("out_err", out_err, e.err);
            end
        end
        prev_ov = out_valid;
        prev_ordy = out_ready;
        prev_code = out_code;
        prev_id = out_id;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (req_q[i].size() > 0);
            req_data[16*i +: 16] = req_valid[i] ? req_q[i][0]
                                                : 16'($urandom);
        end
        #1;
        hs_snap = req_valid & req_ready;
        ok = ((req_ready & ~req_valid) == '0) && $onehot0(req_ready)
             && (!busy || req_ready == '0);
        chk("ready_ok", ok, 1);
    endtask

    // Round-robin reference over the loaded queues.
    task automatic build_exp();
        logic [15:0] cq[NR][$];
        bit found;
        int idx;
        for (int i = 0; i < NR; i++) cq[i] = req_q[i];
        while (1) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (!found && cq[idx].size() > 0) begin
                    found = 1'b1;
                    exp_q.push_back('{id: idx,
                                      code: rns(cq[idx].pop_front()),
                                      err: 1'b0});
                    m_ptr = (idx + 1) % NR;
                end
            end
            if (!found) break;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || inflight) && t < 3000) begin
            step();
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic run_batch();
        build_exp();
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hs_snap = '0;
        inflight = 1'b0;
        out_hs = 1'b0;
        prev_ov = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_enc_start", enc_start, 0);
        chk("rst_enc_data", enc_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        int s0;
        int t;
        int cnt;
        logic [15:0] w;
        bit any;
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        #1;
        do_reset();

        s0 = n_start;
        req_q[0].push_back(16'd100);
        run_batch();
        chk("t1_code", last_code, pack9(36, 37, 35, 33, 29, 27, 21, 17, 11));
        chk("t1_id", last_id, 0);
        chk("t1_starts", n_start - s0, 1);

        do_reset();
        s0 = n_start;
        req_q[0].push_back(16'd0);
        req_q[1].push_back(16'd1);
        req_q[2].push_back(16'd100);
        req_q[3].push_back(16'hFFFF);
        run_batch();
        chk("t2_code", last_code, pack9(63, 15, 15, 9, 2, 54, 44, 48, 31));
        chk("t2_id", last_id, 3);
        chk("t2_starts", n_start - s0, 4);

        for (int j = 0; j < 2; j++) begin
            req_q[0].push_back(16'($urandom));
            req_q[2].push_back(16'($urandom));
        end
        run_batch();
        chk("t3_last_id", last_id, 2);

        stall_left = 10;
        req_q[0].push_back(16'd4242);
        req_q[1].push_back(16'd777);
        run_batch();
        chk("t4_stall_used", stall_left, 0);

        enc_lat = 30;
        s0 = n_start;
        req_q[0].push_back(16'd500);
        t = 0;
        while (n_start == s0 && t < 50) begin
            step();
            t++;
        end
        chk("t5_start", n_start - s0, 1);
        repeat (5) step();
        do_reset();
        repeat (40) step();
        chk("t5_busy", busy, 0);
        chk("t5_valid", out_valid, 0);
        enc_lat = 3;
        req_q[1].push_back(16'd12345);
        run_batch();
        chk("t5_code", last_code, pack9(57, 60, 60, 17, 62, 8, 21, 61, 63));
        chk("t5_id", last_id, 1);

`ifdef RRNS_SCHED_TIMEOUT_EN
        enc_lat = 1000;
        req_q[0].push_back(16'd777);
        build_exp();
        exp_q[exp_q.size()-1].code = '0;
        exp_q[exp_q.size()-1].err = 1'b1;
        drain();
        enc_lat = 16;
        req_q[0].push_back(16'd778);
        build_exp();
        exp_q[exp_q.size()-1].code = '0;
        exp_q[exp_q.size()-1].err = 1'b1;
        drain();
        enc_lat = 15;
        req_q[0].push_back(16'd779);
        run_batch();
        chk("t6_err_edge", last_code, rns(16'd779));
        enc_lat = 3;
`endif

        for (int b = 0; b < 25; b++) begin
            rdy_pct = $urandom_range(30, 100);
            enc_lat = $urandom_range(1, 6);
            enc_level = 1'($urandom_range(1));
            any = 1'b0;
            for (int i = 0; i < NR; i++) begin
                cnt = $urandom_range(3);
                for (int j = 0; j < cnt; j++) begin
                    case ($urandom_range(9))
                        0:       w = 16'h0000;
                        1:       w = 16'hFFFF;
                        default: w = 16'($urandom);
                    endcase
                    req_q[i].push_back(w);
                    any = 1'b1;
                end
            end
            if (any) run_batch();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
